// File: rtl/mapper4510_pkg.sv
// Shared types and constants for the 4510 mapper hypervisor context sequencer.
// Register selects match the mapper's load_a/x/y/z ordering.
package mapper4510_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_LOAD,
        ST_RESTORE,
        ST_SETTLE
    } seq_state_t;

    localparam logic [1:0] REG_A = 2'd3;
    localparam logic [1:0] REG_X = 2'd2;
    localparam logic [1:0] REG_Y = 2'd1;
    localparam logic [1:0] REG_Z = 2'd0;

    localparam logic [7:0] HYP_MAP_A_DEF = 8'h00;
    localparam logic [7:0] HYP_MAP_X_DEF = 8'h00;
    localparam logic [7:0] HYP_MAP_Y_DEF = 8'h80;
    localparam logic [7:0] HYP_MAP_Z_DEF = 8'h3F;

endpackage

// File: rtl/mapper4510_shadow_rf.sv
// Shadow copy of the user map-set-0 bytes, 4 x 8 bits.
// One write port, one combinational read port.
module mapper4510_shadow_rf (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [4];

    // Capture a mapper byte while saving the user context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mapper4510_ctx_seq.sv
// Hypervisor context sequencer: saves/loads/restores mapper set 0
// around hypervisor traps and arbitrates direct register writes.
module mapper4510_ctx_seq
    import mapper4510_pkg::*;
#(
    parameter logic [7:0] HYP_MAP_A    = HYP_MAP_A_DEF,
    parameter logic [7:0] HYP_MAP_X    = HYP_MAP_X_DEF,
    parameter logic [7:0] HYP_MAP_Y    = HYP_MAP_Y_DEF,
    parameter logic [7:0] HYP_MAP_Z    = HYP_MAP_Z_DEF,
    parameter logic [5:0] BUSY_TIMEOUT = 6'd48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trap_enter,
    input  logic       trap_exit,
    input  logic       hyp_wr,
    input  logic [1:0] hyp_wr_sel,
    input  logic [7:0] hyp_wr_data,
    output logic       hyp_wr_ready,
    input  logic       map_active,
    input  logic [7:0] map_reg_data,
    output logic [1:0] map_rd_sel,
    input  logic       mapper_busy,
    output logic       load_a,
    output logic       load_x,
    output logic       load_y,
    output logic       load_z,
    output logic       load_map_sel,
    output logic [7:0] load_data,
    output logic       cpu_hold,
    output logic       in_hyper,
    output logic       seq_done,
    output logic       timeout_err
);

    seq_state_t state_q, state_n;
    logic [1:0] idx_q, idx_n;
    logic [5:0] cnt_q, cnt_n;
    logic       to_hyp_q, to_hyp_n;
    logic [3:0] stb_q, stb_n;
    logic [7:0] data_q, data_n;
    logic       done_q, done_n;
    logic       hyp_q, hyp_n;
    logic       terr_q, terr_n;
    logic       hold_q, hold_n;
    logic       pen_q, pen_n;
    logic       pex_q, pex_n;

    logic       start_en;
    logic       start_ex;
    logic       sh_we;
    logic [7:0] sh_rdata;
    logic [7:0] hyp_byte;
    logic       settle_ok;
    logic       settle_to;

    mapper4510_shadow_rf u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (sh_we),
        .waddr (idx_q),
        .wdata (map_reg_data),
        .raddr (idx_q),
        .rdata (sh_rdata)
    );

    // Hypervisor map byte for the register currently being walked
    always_comb begin
        hyp_byte = HYP_MAP_Z;
        unique case (1'b1)
            idx_q == REG_A: hyp_byte = HYP_MAP_A;
            idx_q == REG_X: hyp_byte = HYP_MAP_X;
            idx_q == REG_Y: hyp_byte = HYP_MAP_Y;
            default:        hyp_byte = HYP_MAP_Z;
        endcase
    end

    // Next-state, start arbitration and registered-output values
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        to_hyp_n = to_hyp_q;
        stb_n    = '0;
        data_n   = data_q;
        done_n   = 1'b0;
        hyp_n    = hyp_q;
        terr_n   = terr_q;
        pen_n    = pen_q | trap_enter;
        pex_n    = pex_q | trap_exit;
        sh_we    = 1'b0;
        start_en = 1'b0;
        start_ex = 1'b0;
        hyp_wr_ready = 1'b0;
        settle_ok = (cnt_q != 6'd0) & ~mapper_busy;
        settle_to = (cnt_q == BUSY_TIMEOUT - 6'd1) & ~settle_ok;

        unique case (state_q)
            ST_IDLE: begin
                if (!map_active) begin
                    start_en = pen_n & ~hyp_q;
                    start_ex = pex_n & hyp_q;
                    pen_n = 1'b0;
                    pex_n = 1'b0;
                    if (start_en) begin
                        state_n  = ST_SAVE;
                        idx_n    = REG_A;
                        to_hyp_n = 1'b1;
                        terr_n   = 1'b0;
                    end else if (start_ex) begin
                        state_n  = ST_RESTORE;
                        idx_n    = REG_A;
                        to_hyp_n = 1'b0;
                    end else if (hyp_wr) begin
                        hyp_wr_ready      = 1'b1;
                        stb_n[hyp_wr_sel] = 1'b1;
                        data_n            = hyp_wr_data;
                    end
                end
            end
            ST_SAVE: begin
                sh_we = 1'b1;
                idx_n = idx_q - 2'd1;
                if (idx_q == REG_Z) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                stb_n[idx_q] = 1'b1;
                data_n       = hyp_byte;
                idx_n        = idx_q - 2'd1;
                if (idx_q == REG_Z) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
            end
            ST_RESTORE: begin
                stb_n[idx_q] = 1'b1;
                data_n       = sh_rdata;
                idx_n        = idx_q - 2'd1;
                if (idx_q == REG_Z) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_n = cnt_q + 6'd1;
                if (settle_ok || settle_to) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    hyp_n   = to_hyp_q;
                    if (settle_to) begin
                        terr_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        hold_n = start_en | start_ex | (state_q != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            to_hyp_q <= 1'b0;
            stb_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            hyp_q    <= 1'b0;
            terr_q   <= 1'b0;
            hold_q   <= 1'b0;
            pen_q    <= 1'b0;
            pex_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            to_hyp_q <= to_hyp_n;
            stb_q    <= stb_n;
            data_q   <= data_n;
            done_q   <= done_n;
            hyp_q    <= hyp_n;
            terr_q   <= terr_n;
            hold_q   <= hold_n;
            pen_q    <= pen_n;
            pex_q    <= pex_n;
        end
    end

    assign map_rd_sel   = (state_q == ST_SAVE) ? idx_q : 2'd0;
    assign load_a       = stb_q[REG_A];
    assign load_x       = stb_q[REG_X];
    assign load_y       = stb_q[REG_Y];
    assign load_z       = stb_q[REG_Z];
    assign load_map_sel = 1'b0;
    assign load_data    = data_q;
    assign cpu_hold     = hold_q;
    assign in_hyper     = hyp_q;
    assign seq_done     = done_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mapper4510_ctx_seq.sv
// Directed bench for mapper4510_ctx_seq with a small mapper model
// that holds the map bytes and raises busy for 32 cycles after load_z.
module tb_mapper4510_ctx_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trap_enter = 1'b0;
    logic       trap_exit = 1'b0;
    logic       hyp_wr = 1'b0;
    logic [1:0] hyp_wr_sel = 2'd0;
    logic [7:0] hyp_wr_data = 8'd0;
    logic       hyp_wr_ready;
    logic       map_active = 1'b0;
    logic [7:0] map_reg_data;
    logic [1:0] map_rd_sel;
    logic       mapper_busy;
    logic       load_a, load_x, load_y, load_z;
    logic       load_map_sel;
    logic [7:0] load_data;
    logic       cpu_hold, in_hyper, seq_done, timeout_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int at = 0;
    int cnt = 0;

    logic [7:0] mregs [4];
    int   bcnt = 0;
    logic stuck = 1'b0;
    logic [3:0] stb;

    mapper4510_ctx_seq dut (
        .clk          (clk),
        .reset        (reset),
        .trap_enter   (trap_enter),
        .trap_exit    (trap_exit),
        .hyp_wr       (hyp_wr),
        .hyp_wr_sel   (hyp_wr_sel),
        .hyp_wr_data  (hyp_wr_data),
        .hyp_wr_ready (hyp_wr_ready),
        .map_active   (map_active),
        .map_reg_data (map_reg_data),
        .map_rd_sel   (map_rd_sel),
        .mapper_busy  (mapper_busy),
        .load_a       (load_a),
        .load_x       (load_x),
        .load_y       (load_y),
        .load_z       (load_z),
        .load_map_sel (load_map_sel),
        .load_data    (load_data),
        .cpu_hold     (cpu_hold),
        .in_hyper     (in_hyper),
        .seq_done     (seq_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    assign stb          = {load_a, load_x, load_y, load_z};
    assign map_reg_data = mregs[map_rd_sel];
    assign mapper_busy  = (bcnt != 0) | stuck;

    always @(posedge clk) begin
        if (load_a) mregs[3] <= load_data;
        if (load_x) mregs[2] <= load_data;
        if (load_y) mregs[1] <= load_data;
        if (load_z) mregs[0] <= load_data;
        if (load_z) bcnt <= 32;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int lim, output int when);
        when = -1;
        for (int i = 0; i < lim; i++) begin
            step();
            if (seq_done) begin
                when = cyc;
                return;
            end
        end
    endtask

    initial begin
        mregs[3] = 8'h12;
        mregs[2] = 8'h34;
        mregs[1] = 8'h56;
        mregs[0] = 8'h78;

        // reset state
        step();
        step();
        chk("rst_stb", {28'd0, stb}, 0);
        chk("rst_data", {24'd0, load_data}, 0);
        chk("rst_hold", {31'd0, cpu_hold}, 0);
        chk("rst_hyp", {31'd0, in_hyper}, 0);
        chk("rst_done", {31'd0, seq_done}, 0);
        chk("rst_terr", {31'd0, timeout_err}, 0);
        chk("rst_sel", {31'd0, load_map_sel}, 0);
        reset = 1'b1;
        step();

        // enter from reset
        t0 = cyc;
        trap_enter = 1'b1;
        step();
        trap_enter = 1'b0;
        chk("en_hold", {31'd0, cpu_hold}, 1);
        chk("en_rd3", {30'd0, map_rd_sel}, 3);
        step();
        chk("en_rd2", {30'd0, map_rd_sel}, 2);
        step();
        chk("en_rd1", {30'd0, map_rd_sel}, 1);
        step();
        chk("en_rd0", {30'd0, map_rd_sel}, 0);
        step();
        chk("en_nostb", {28'd0, stb}, 0);
        step();
        chk("en_a", {20'd0, stb, load_data}, {20'd0, 4'b1000, 8'h00});
        step();
        chk("en_x", {20'd0, stb, load_data}, {20'd0, 4'b0100, 8'h00});
        step();
        chk("en_y", {20'd0, stb, load_data}, {20'd0, 4'b0010, 8'h80});
        step();
        chk("en_z", {20'd0, stb, load_data}, {20'd0, 4'b0001, 8'h3F});
        wait_done(80, at);
        chk("en_lat", at - t0, 43);
        chk("en_hyp", {31'd0, in_hyper}, 1);
        chk("en_hold_done", {31'd0, cpu_hold}, 1);
        step();
        chk("en_hold_off", {31'd0, cpu_hold}, 0);
        chk("en_done_off", {31'd0, seq_done}, 0);

        // exit restores saved bytes
        t0 = cyc;
        trap_exit = 1'b1;
        step();
        trap_exit = 1'b0;
        step();
        chk("ex_a", {20'd0, stb, load_data}, {20'd0, 4'b1000, 8'h12});
        step();
        chk("ex_x", {20'd0, stb, load_data}, {20'd0, 4'b0100, 8'h34});
        step();
        chk("ex_y", {20'd0, stb, load_data}, {20'd0, 4'b0010, 8'h56});
        step();
        chk("ex_z", {20'd0, stb, load_data}, {20'd0, 4'b0001, 8'h78});
        wait_done(80, at);
        chk("ex_lat", at - t0, 39);
        chk("ex_hyp", {31'd0, in_hyper}, 0);
        step();
        chk("ex_mregs", {mregs[3], mregs[2], mregs[1], mregs[0]},
            32'h12345678);

        // enter deferred by map_active
        t0 = cyc;
        map_active = 1'b1;
        trap_enter = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (stb != 4'd0) cnt++;
            if (i <= 5 && cpu_hold) cnt++;
            step();
            if (i == 1) trap_enter = 1'b0;
            if (i == 5) map_active = 1'b0;
            if (i == 6) chk("df_hold", {31'd0, cpu_hold}, 1);
        end
        chk("df_quiet", cnt, 0);
        step();
        chk("df_a", {20'd0, stb, load_data}, {20'd0, 4'b1000, 8'h00});
        wait_done(80, at);
        chk("df_lat", at - t0, 48);
        chk("df_hyp", {31'd0, in_hyper}, 1);

        // plain exit to get back to user map
        step();
        trap_exit = 1'b1;
        step();
        trap_exit = 1'b0;
        wait_done(80, at);
        chk("ex2_hyp", {31'd0, in_hyper}, 0);

        // direct write held across an enter sequence
        step();
        t0 = cyc;
        trap_enter = 1'b1;
        hyp_wr = 1'b1;
        hyp_wr_sel = 2'd2;
        hyp_wr_data = 8'hA5;
        #1;
        chk("ar_prio", {31'd0, hyp_wr_ready}, 0);
        step();
        trap_enter = 1'b0;
        cnt = 0;
        for (int i = 1; i < 43; i++) begin
            if (hyp_wr_ready) cnt++;
            step();
        end
        chk("ar_blocked", cnt, 0);
        chk("ar_done", {31'd0, seq_done}, 1);
        chk("ar_ready", {31'd0, hyp_wr_ready}, 1);
        step();
        hyp_wr = 1'b0;
        chk("ar_x", {20'd0, stb, load_data}, {20'd0, 4'b0100, 8'hA5});

        // exit with busy stuck high
        step();
        t0 = cyc;
        trap_exit = 1'b1;
        stuck = 1'b1;
        step();
        trap_exit = 1'b0;
        wait_done(100, at);
        chk("to_lat", at - t0, 53);
        chk("to_err", {31'd0, timeout_err}, 1);
        chk("to_hold", {31'd0, cpu_hold}, 1);
        chk("to_hyp", {31'd0, in_hyper}, 0);
        step();
        stuck = 1'b0;
        chk("to_hold_off", {31'd0, cpu_hold}, 0);
        chk("to_sticky", {31'd0, timeout_err}, 1);
        for (int i = 0; i < 40; i++) step();

        // reset in the middle of LOAD
        t0 = cyc;
        trap_enter = 1'b1;
        step();
        trap_enter = 1'b0;
        chk("rl_terr_clr", {31'd0, timeout_err}, 0);
        for (int i = 0; i < 5; i++) step();
        chk("rl_a", {28'd0, stb}, 4'b1000);
        step();
        reset = 1'b0;
        #1;
        chk("rl_stb", {28'd0, stb}, 0);
        chk("rl_data", {24'd0, load_data}, 0);
        chk("rl_hold", {31'd0, cpu_hold}, 0);
        chk("rl_hyp", {31'd0, in_hyper}, 0);
        chk("rl_rdsel", {30'd0, map_rd_sel}, 0);
        step();
        reset = 1'b1;
        step();
        trap_exit = 1'b1;
        step();
        trap_exit = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (stb != 4'd0 || cpu_hold || seq_done) cnt++;
            step();
        end
        chk("rl_exit_ign", cnt, 0);
        chk("rl_hyp2", {31'd0, in_hyper}, 0);

        // direct Z write from idle
        hyp_wr = 1'b1;
        hyp_wr_sel = 2'd0;
        hyp_wr_data = 8'h5A;
        #1;
        chk("dz_ready", {31'd0, hyp_wr_ready}, 1);
        step();
        hyp_wr = 1'b0;
        chk("dz_z", {20'd0, stb, load_data}, {20'd0, 4'b0001, 8'h5A});
        chk("dz_hold", {31'd0, cpu_hold}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
